stage1_issue: RTL
=================

Name: stage1_issue

Overview:
- Decode/issue stage driving the stage-2 ALU inputs.
- Accepts 32-bit instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives registered aluin1, aluin2, operation, opselect, shift_number, enable_arith and enable_shift for one cycle per issued op.
- Closes the loop via a writeback port fed from ALU results; a scoreboard interlocks RAW/WAW hazards.

Parameters:
N, 32, datapath width
REGS, 8, register file depth (index width log2(REGS)=3)
IMMW, 14, immediate field width, sign-extended to N

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present
instr  input  32  instruction word
instr_ready  output  1  stage can accept instr this cycle
wb_en  input  1  writeback strobe
wb_addr  input  3  writeback destination register
wb_data  input  N  writeback data (ALU aluout)
wb_carry  input  1  writeback carry (ALU carry)
aluin1  output  N  operand 1
aluin2  output  N  operand 2
operation  output  3  ALU operation code
opselect  output  3  ALU op select
shift_number  output  5  shift amount
enable_arith  output  1  arithmetic op issued (1-cycle pulse)
enable_shift  output  1  shift op issued (1-cycle pulse)
issue_dest  output  3  destination register of issued op
carry_flag  output  1  last written-back carry
illegal_instr  output  1  1-cycle pulse on accepted class-11 instr

Behaviour:
- Instr fields:
  - [31:30] class: 00 arith, 01 shift, 10 NOP, 11 illegal.
  - [29:27] operation; [26:24] opselect; [23:21] dest; [20:18] src1; [17:15] src2.
  - [14] imm_sel; [13:0] imm.
- Handshake: accept when instr_valid & instr_ready at a rising edge. instr_ready is combinational from scoreboard/wb state and does not depend on instr_valid content other than src/dest fields.
- Register file: r0 reads 0, writes to r0 ignored, r0 never pending. Write on wb_en at clock edge; carry_flag <= wb_carry on any wb_en, including to r0.
- Operands:
  - aluin1 = R[src1].
  - aluin2 = imm_sel ? sext(imm) : R[src2].
  - shift_number = imm_sel ? imm[4:0] : R[src2][4:0].
  - Shift class still drives aluin2 per the same rule.
- Latency: instruction accepted at edge t drives outputs from t until the next edge (registered, 1 cycle).
  - enable_arith=1 for class 00 only; enable_shift=1 for class 01 only; both never 1 together.
  - When no issue: enables=0, illegal_instr=0, data outputs hold last value.
- Scoreboard: pending[REGS] bits.
  - Accept of class 00/01 with dest!=0 sets pending[dest].
  - wb_en clears pending[wb_addr].
  - Same-edge set and clear on the same register: set wins.
- Hazard: instr_ready=0 when instr_valid and class 00/01 and any of:
  - pending[src1];
  - pending[src2] with imm_sel=0;
  - pending[dest].
- NOP/illegal: never stall; no pending update. Illegal asserts illegal_instr for one cycle.
- Writeback to a non-pending register: allowed, written, no error.
- Reset (async, low):
  - All outputs 0, instr_ready=1.
  - Register file, pending and carry_flag cleared.
  - In-flight issue is discarded.
  - First accept possible at the first edge after reset deasserts.

Optional Feature:
- Macro STAGE1_BYPASS_EN.
- Defined: a source whose pending bit is set but which matches wb_addr with wb_en in the same cycle counts as ready, and its operand is taken from wb_data (and wb_data[4:0] for shift_number). The instruction issues in the writeback cycle. A WAW on dest cleared by the same-cycle wb also does not stall.
- Undefined: stall until pending clears; the instruction accepts the cycle after writeback and reads the written value from the register file.

Test Plan:
- Reset: reset low mid-issue -> all outputs 0, instr_ready=1. wb r3=0x55 then arith op src1=3, operation=3'b010, opselect=3'b001 -> aluin1=0x55, enable_arith pulse 1 cycle, issue_dest as encoded.
- Immediate: shift class, imm_sel=1, imm=0x3FFF, src1=r2 (=0x80000000) -> aluin2=0xFFFFFFFF, shift_number=5'h1F, enable_shift=1, enable_arith=0.
- RAW stall, no bypass:
  - Issue dest=r4, then instr src1=r4 -> instr_ready=0.
  - wb r4=0x1234 at cycle w -> accept at w+1, aluin1=0x1234.
  - With STAGE1_BYPASS_EN -> accept at w, aluin1=0x1234.
- WAW and same-edge set/clear: issue dest=r5; wb r5 while next instr with dest=r5 accepted same edge -> pending[5] remains 1, third instr reading r5 stalls.
- NOP/illegal: class 10 -> accepted, no enables. Class 11 -> illegal_instr 1 cycle, no pending set, data outputs unchanged.
- r0 rules: wb r0=0xFFFF, wb_carry=1 -> r0 reads 0, carry_flag=1. Issue dest=r0 -> no pending, back-to-back instr using r0 never stalls.

Source files
------------

// File: rtl/stage1_issue.sv
// stage1_issue: decode/issue stage feeding the stage-2 ALU.
// Optional same-cycle writeback forwarding is enabled by defining STAGE1_BYPASS_EN.
module stage1_issue #(
  parameter int N    = 32,
  parameter int REGS = 8,
  parameter int IMMW = 14
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         instr_valid,
  input  logic [31:0]  instr,
  output logic         instr_ready,
  input  logic         wb_en,
  input  logic [2:0]   wb_addr,
  input  logic [N-1:0] wb_data,
  input  logic         wb_carry,
  output logic [N-1:0] aluin1,
  output logic [N-1:0] aluin2,
  output logic [2:0]   operation,
  output logic [2:0]   opselect,
  output logic [4:0]   shift_number,
  output logic         enable_arith,
  output logic         enable_shift,
  output logic [2:0]   issue_dest,
  output logic         carry_flag,
  output logic         illegal_instr
);

  logic [1:0]      cls;
  logic [2:0]      f_op;
  logic [2:0]      f_sel;
  logic [2:0]      dest;
  logic [2:0]      src1;
  logic [2:0]      src2;
  logic            imm_sel;
  logic [IMMW-1:0] imm;
  logic [N-1:0]    imm_ext;

  logic is_arith;
  logic is_shift;
  logic is_nop;
  logic is_ill;
  logic is_op;

  logic [N-1:0] rf_q [REGS];
  logic [N-1:0] rf_d [REGS];
  logic [REGS-1:0] pending_q;
  logic [REGS-1:0] pending_d;
  logic carry_q;
  logic carry_d;

  logic [N-1:0] src1_val;
  logic [N-1:0] src2_val;
  logic busy1;
  logic busy2;
  logic busyd;
  logic hazard;
  logic accept;

  logic [N-1:0] aluin1_q, aluin1_d;
  logic [N-1:0] aluin2_q, aluin2_d;
  logic [2:0]   op_q, op_d;
  logic [2:0]   sel_q, sel_d;
  logic [4:0]   sh_q, sh_d;
  logic         ea_q, ea_d;
  logic         es_q, es_d;
  logic [2:0]   dst_q, dst_d;
  logic         ill_q, ill_d;

  // Instruction field extraction and immediate sign extension
  always_comb begin
    cls     = instr[31:30];
    f_op    = instr[29:27];
    f_sel   = instr[26:24];
    dest    = instr[23:21];
    src1    = instr[20:18];
    src2    = instr[17:15];
    imm_sel = instr[14];
    imm     = instr[IMMW-1:0];
    imm_ext = {{(N-IMMW){imm[IMMW-1]}}, imm};
  end

  // Class decode: exactly one class flag is set
  always_comb begin
    is_arith = 1'b0;
    is_shift = 1'b0;
    is_nop   = 1'b0;
    is_ill   = 1'b0;
    unique case (cls)
      2'b00:   is_arith = 1'b1;
      2'b01:   is_shift = 1'b1;
      2'b10:   is_nop   = 1'b1;
      default: is_ill   = 1'b1;
    endcase
    is_op = is_arith | is_shift;
  end

  // Operand read, optionally forwarding the same-cycle writeback
  always_comb begin
    src1_val = rf_q[src1];
    src2_val = rf_q[src2];
`ifdef STAGE1_BYPASS_EN
    if (wb_en && wb_addr == src1 && src1 != 3'd0)
      src1_val = wb_data;
    if (wb_en && wb_addr == src2 && src2 != 3'd0)
      src2_val = wb_data;
`endif
  end

  // Hazard detection against the pending scoreboard
  always_comb begin
`ifdef STAGE1_BYPASS_EN
    busy1 = pending_q[src1] && !(wb_en && wb_addr == src1);
    busy2 = pending_q[src2] && !(wb_en && wb_addr == src2);
    busyd = pending_q[dest] && !(wb_en && wb_addr == dest);
`else
    busy1 = pending_q[src1];
    busy2 = pending_q[src2];
    busyd = pending_q[dest];
`endif
    hazard      = busy1 | (busy2 & ~imm_sel) | busyd;
    instr_ready = ~(instr_valid & is_op & hazard);
    accept      = instr_valid & instr_ready;
  end

  // Register file and carry next state; r0 stays zero
  always_comb begin
    rf_d = rf_q;
    if (wb_en && wb_addr != 3'd0)
      rf_d[wb_addr] = wb_data;
    rf_d[0] = '0;
    carry_d = wb_en ? wb_carry : carry_q;
  end

  // Scoreboard: writeback clears, issue sets, set wins on a tie
  always_comb begin
    pending_d = pending_q;
    if (wb_en)
      pending_d[wb_addr] = 1'b0;
    if (accept && is_op && dest != 3'd0)
      pending_d[dest] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Issue outputs: pulses default low, data holds unless an op issues
  always_comb begin
    aluin1_d = aluin1_q;
    aluin2_d = aluin2_q;
    op_d     = op_q;
    sel_d    = sel_q;
    sh_d     = sh_q;
    dst_d    = dst_q;
    ea_d     = 1'b0;
    es_d     = 1'b0;
    ill_d    = 1'b0;
    if (accept) begin
      unique case (1'b1)
        is_op: begin
          aluin1_d = src1_val;
          aluin2_d = imm_sel ? imm_ext : src2_val;
          sh_d     = imm_sel ? imm[4:0] : src2_val[4:0];
          op_d     = f_op;
          sel_d    = f_sel;
          dst_d    = dest;
          ea_d     = is_arith;
          es_d     = is_shift;
        end
        is_ill:  ill_d = 1'b1;
        is_nop:  ill_d = 1'b0;
        default: ill_d = 1'b0;
      endcase
    end
  end

  // State registers; reset discards any in-flight issue
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++)
        rf_q[i] <= '0;
      pending_q <= '0;
      carry_q   <= 1'b0;
      aluin1_q  <= '0;
      aluin2_q  <= '0;
      op_q      <= '0;
      sel_q     <= '0;
      sh_q      <= '0;
      dst_q     <= '0;
      ea_q      <= 1'b0;
      es_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      rf_q      <= rf_d;
      pending_q <= pending_d;
      carry_q   <= carry_d;
      aluin1_q  <= aluin1_d;
      aluin2_q  <= aluin2_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      sh_q      <= sh_d;
      dst_q     <= dst_d;
      ea_q      <= ea_d;
      es_q      <= es_d;
      ill_q     <= ill_d;
    end
  end

  assign aluin1        = aluin1_q;
  assign aluin2        = aluin2_q;
  assign operation     = op_q;
  assign opselect      = sel_q;
  assign shift_number  = sh_q;
  assign enable_arith  = ea_q;
  assign enable_shift  = es_q;
  assign issue_dest    = dst_q;
  assign carry_flag    = carry_q;
  assign illegal_instr = ill_q;

endmodule
